// File: rtl/run_seq_pkg.sv
// Shared state encoding and parameter defaults for the run-control sequencer.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        REPORT,
        DONE,
        ERR
    } run_state_t;

    localparam int DEFAULT_START_CYCLES   = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/run_cycle_counter.sv
// Clearable, enabled up-counter with a terminal-count compare against a fixed value.
module run_cycle_counter #(
    parameter int               CNT_W = 16,
    parameter logic [CNT_W-1:0] TERM  = '1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Enable,
    output logic [CNT_W-1:0] Count,
    output logic             AtTerm
);

    // NOTE: clocked state is written with non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            Count <= '0;
        end else if (Enable) begin
            Count <= Count + CNT_W'(1);
        end
    end

    assign AtTerm = (Count == TERM);

endmodule

// File: rtl/run_sequencer.sv
// Launches programs 0..NUM_PROGS-1 on the core back-to-back, timing each until Ack
// and aborting any program that overruns its cycle budget.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int  NUM_PROGS      = 3,
    parameter int  CNT_W          = 16,
    parameter int  START_CYCLES   = DEFAULT_START_CYCLES,
    parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int SEL_W          = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             CoreAck,
    output logic             CoreStart,
    output logic [SEL_W-1:0] ProgSel,
    output logic             Busy,
    output logic [CNT_W-1:0] CycleCount,
    output logic             CountValid,
    output logic             Done,
    output logic             TimedOut
);

    localparam int                  LAUNCH_W    = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [LAUNCH_W-1:0] LAUNCH_TERM = LAUNCH_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0]    RUN_TERM    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0]    LAST_PROG   = SEL_W'(NUM_PROGS - 1);

    run_state_t          state, nextState;
    logic [LAUNCH_W-1:0] launchCount;
    logic [CNT_W-1:0]    runCount;
    logic                runAtTerm;
    logic                runEnable;

    logic [SEL_W-1:0]    nextProgSel;
    logic [CNT_W-1:0]    nextCycleCount;
    logic                nextCountValid, nextDone, nextTimedOut, nextCoreStart, nextBusy;

    always_ff @(posedge Clk) begin
        if (Reset || state != LAUNCH) begin
            launchCount <= '0;
        end else begin
            launchCount <= launchCount + LAUNCH_W'(1);
        end
    end

    // Held at zero throughout LAUNCH so the first RUN cycle sees a count of 0.
    assign runEnable = (state == RUN) && !CoreAck && !runAtTerm;

    run_cycle_counter #(
        .CNT_W (CNT_W),
        .TERM  (RUN_TERM)
    ) runCounter (
        .Clk    (Clk),
        .Reset  (Reset),
        .Clear  (state == LAUNCH),
        .Enable (runEnable),
        .Count  (runCount),
        .AtTerm (runAtTerm)
    );

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        nextState      = state;
        nextProgSel    = ProgSel;
        nextCycleCount = CycleCount;
        nextCountValid = 1'b0;
        nextDone       = Done;
        nextTimedOut   = TimedOut;

        case (state)
            IDLE: begin
                if (Go) begin
                    nextState    = LAUNCH;
                    nextProgSel  = '0;
                    nextDone     = 1'b0;
                    nextTimedOut = 1'b0;
                end
            end
            LAUNCH: begin
                if (launchCount == LAUNCH_TERM) nextState = RUN;
            end
            RUN: begin
                if (CoreAck) begin
                    nextState      = REPORT;
                    nextCycleCount = runCount;
                    nextCountValid = 1'b1;
                end else if (runAtTerm) begin
                    nextState    = ERR;
                    nextTimedOut = 1'b1;
                end
            end
            REPORT: begin
                if (ProgSel == LAST_PROG) begin
                    nextState = DONE;
                    nextDone  = 1'b1;
                end else begin
                    nextState   = LAUNCH;
                    nextProgSel = ProgSel + SEL_W'(1);
                end
            end
            DONE, ERR: begin
                if (!Go) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it exactly.
        nextCoreStart = (nextState != RUN);
        nextBusy      = (nextState == LAUNCH) || (nextState == RUN) || (nextState == REPORT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            CoreStart  <= 1'b1;
            ProgSel    <= '0;
            Busy       <= 1'b0;
            CycleCount <= '0;
            CountValid <= 1'b0;
            Done       <= 1'b0;
            TimedOut   <= 1'b0;
        end else begin
            state      <= nextState;
            CoreStart  <= nextCoreStart;
            ProgSel    <= nextProgSel;
            Busy       <= nextBusy;
            CycleCount <= nextCycleCount;
            CountValid <= nextCountValid;
            Done       <= nextDone;
            TimedOut   <= nextTimedOut;
        end
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Run-control stage directly upstream of the 3BC processor top level. It launches each program in turn by driving the core's `Start` input and consumes the core's `Ack` done flag. It measures cycles-to-Ack per program and aborts any program that exceeds a cycle budget. Lets one `Go` request execute programs 0..NUM_PROGS-1 back-to-back with no bench intervention between programs.

## Interface
Parameters:
- `NUM_PROGS`, default 3: programs per run, ≥1.
- `CNT_W`, default 16: width of the cycle counter and the reported count.
- `START_CYCLES`, default 2: cycles `CoreStart` is held high in LAUNCH, ≥1.
- `TIMEOUT_CYCLES`, default 16'd50000: RUN-cycle budget per program, < 2^CNT_W.

Ports:
- `Clk` input 1: clock, posedge.
- `Reset` input 1: synchronous, active-high.
- `Go` input 1: level request to run all programs.
- `CoreAck` input 1: `Ack` from the processor; level, may be stale-high from the previous program.
- `CoreStart` output 1: to processor `Start`. High parks the core; the falling edge begins execution.
- `ProgSel` output $clog2(NUM_PROGS) (min 1): index of the current program, to the instruction ROM bank select.
- `Busy` output 1: high in LAUNCH, RUN and REPORT.
- `CycleCount` output CNT_W: cycles of the last completed program; holds its value between reports.
- `CountValid` output 1: one-cycle pulse when `CycleCount` updates.
- `Done` output 1: all programs finished normally.
- `TimedOut` output 1: a program exceeded its budget.

## Operation
- States: IDLE, LAUNCH, RUN, REPORT, DONE, ERR.
- IDLE:
  - `CoreStart`=1.
  - When `Go`=1: ProgSel←0, Done←0, TimedOut←0, go to LAUNCH.
- LAUNCH:
  - `CoreStart`=1 for exactly START_CYCLES cycles; then go to RUN.
  - Run counter cleared to 0 on entry.
  - `CoreAck` is ignored in this state.
- RUN:
  - `CoreStart`=0.
  - If `CoreAck`=1: go to REPORT, CycleCount←counter, CountValid pulses in the REPORT cycle.
  - Else if counter == TIMEOUT_CYCLES-1: go to ERR.
  - Else counter+1.
  - Ack has priority over timeout in the same cycle.
- REPORT (1 cycle):
  - `CoreStart`=1.
  - If ProgSel == NUM_PROGS-1: go to DONE.
  - Else ProgSel+1, go to LAUNCH.
- DONE:
  - `Done`=1, `CoreStart`=1.
  - Stays until `Go`=0, then goes to IDLE. `Done` stays high until the next `Go` accepted in IDLE.
- ERR:
  - `TimedOut`=1, `CoreStart`=1, ProgSel frozen at the failing program.
  - Goes to IDLE on `Go`=0; `TimedOut` sticky until the next accepted `Go`.
- Counter arithmetic: unsigned CNT_W. It cannot wrap because timeout fires first.
- `Go` dropping mid-run does not abort; only `Reset` aborts.

## Timing
- Reset values:
  - state IDLE, `CoreStart`=1, `ProgSel`=0, `Busy`=0.
  - `CycleCount`=0, `CountValid`=0, `Done`=0, `TimedOut`=0.
- `Reset` mid-operation: all of the above apply on the next edge; no report is emitted.
- All outputs are registered. No combinational path from `CoreAck` or `Go` to any output.
- `Go` to first `CoreStart` falling edge: 1+START_CYCLES cycles.
- `CoreAck` sampled at edge N → `CountValid` high in cycle N+1 → next LAUNCH at N+2 (or DONE at N+2).
- Per-program overhead between programs: 1 (REPORT) + START_CYCLES cycles.
- `CycleCount` = number of RUN cycles with `CoreAck`=0 before Ack.
- Ack in the first RUN cycle gives a count of 0.

## Structure
- Package `run_seq_pkg`:
  - `run_state_t` enum (6 states).
  - Defaults for START_CYCLES and TIMEOUT_CYCLES.
- One sub-module `run_cycle_counter`: clear / enable / terminal-count compare, parameterised on CNT_W. The FSM and output registers live in `run_sequencer`.

## Test plan
- Reset then Go=1, core model acks after 10 RUN cycles each, NUM_PROGS=3 → three CountValid pulses with CycleCount=10, ProgSel 0→1→2, then Done=1 and Busy=0.
- Stale Ack: CoreAck held high through LAUNCH → not taken; the count reflects the first Ack seen in RUN.
- Core never acks, TIMEOUT_CYCLES=20 → ERR after exactly 20 RUN cycles; TimedOut=1, CoreStart=1, ProgSel frozen, no CountValid.
- Ack on the same cycle the counter hits TIMEOUT_CYCLES-1 → REPORT with CycleCount=19, not ERR.
- Reset asserted mid-RUN of program 1 → next cycle matches all reset values; a following Go restarts at ProgSel=0.
- Go held high after DONE → stays in DONE. Go low then high → Done clears and a new run starts.
